// File: rtl/csr_exec_pkg.sv
// Shared types and constants for the CSR execute unit.
// Holds the op encoding, exception codes and the pipeline stage payloads.
package csr_exec_pkg;

  localparam int unsigned CSR_ADDR_W = 14;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ECODE_W    = 5;

  typedef enum logic [1:0] {
    CSR_RD   = 2'b00,
    CSR_WR   = 2'b01,
    CSR_XCHG = 2'b10,
    CSR_ILL  = 2'b11
  } csr_op_e;

  // Exception codes packed as {ecode[3:0], esubcode[0]}
  localparam logic [ECODE_W-1:0] ECODE_IPE = 5'h1C;
  localparam logic [ECODE_W-1:0] ECODE_INE = 5'h1A;

  typedef struct packed {
    csr_op_e                op;
    logic [CSR_ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]      wdata;
    logic [DATA_W-1:0]      mask;
    logic                   excp;
    logic [ECODE_W-1:0]     ecode;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               csr_write;
    logic               excp;
    logic [ECODE_W-1:0] ecode;
  } s2_t;

  // Returns {excp, ecode}; privilege violation outranks an illegal op.
  function automatic logic [ECODE_W:0] excp_check(input logic [1:0] plv, input logic [1:0] op);
    if (plv != 2'd0) return {1'b1, ECODE_IPE};
    if (op == 2'b11) return {1'b1, ECODE_INE};
    return '0;
  endfunction

endpackage

// File: rtl/csr_merge.sv
// Combinational op decode and write-value merge for the CSR op held in S1.
module csr_merge
  import csr_exec_pkg::*;
(
  input  csr_op_e           op,
  input  logic              excp,
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mask,
  output logic              wr_c,
  output logic [DATA_W-1:0] new_c
);

  always_comb begin
    wr_c  = 1'b0;
    new_c = wdata;
    case (op)
      CSR_WR: begin
        wr_c  = ~excp;
        new_c = wdata;
      end
      CSR_XCHG: begin
        wr_c  = ~excp;
        new_c = (old_val & ~mask) | (wdata & mask);
      end
      default: begin
        wr_c  = 1'b0;
        new_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// CSR execute unit: S1 reads the bypassed CSR and pushes the merged value,
// S2 holds the old value and exception status for writeback.
module csr_exec_unit
  import csr_exec_pkg::*;
#(
  parameter int unsigned PDST_W = 6,
  parameter int unsigned ROB_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_back,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [CSR_ADDR_W-1:0] in_csr_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [DATA_W-1:0]     in_mask,
  input  logic [PDST_W-1:0]     in_pdst,
  input  logic [ROB_W-1:0]      in_rob_idx,
  input  logic [1:0]            plv,
  output logic [CSR_ADDR_W-1:0] csr_rd_addr,
  input  logic [DATA_W-1:0]     csr_rd_data,
  output logic                  csr_wr_en,
  output logic [CSR_ADDR_W-1:0] csr_wr_addr,
  output logic [DATA_W-1:0]     csr_wr_data,
  input  logic                  full_csrfifo,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_W-1:0]     wb_data,
  output logic [PDST_W-1:0]     wb_pdst,
  output logic [ROB_W-1:0]      wb_rob_idx,
  output logic                  wb_csr_write,
  output logic                  wb_excp,
  output logic [ECODE_W-1:0]    wb_excp_code
);

  s1_t                s1_q;
  logic               s1_valid;
  logic [PDST_W-1:0]  s1_pdst;
  logic [ROB_W-1:0]   s1_rob;

  s2_t                s2_q;
  logic               s2_valid;
  logic [PDST_W-1:0]  s2_pdst;
  logic [ROB_W-1:0]   s2_rob;

  logic               merge_wr_c;
  logic [DATA_W-1:0]  new_val_c;
  logic               needs_wr_c;
  logic               s2_free_c;
  logic               s1_fire_c;
  logic               accept_c;
  logic [ECODE_W:0]   excp_in_c;

  csr_merge u_merge (
    .op      (s1_q.op),
    .excp    (s1_q.excp),
    .old_val (csr_rd_data),
    .wdata   (s1_q.wdata),
    .mask    (s1_q.mask),
    .wr_c    (merge_wr_c),
    .new_c   (new_val_c)
  );

  // Handshake and stall network
  assign excp_in_c  = excp_check(plv, in_op);
  assign needs_wr_c = s1_valid & merge_wr_c;
  assign s2_free_c  = ~s2_valid | wb_ready;
  assign s1_fire_c  = s1_valid & s2_free_c & ~(needs_wr_c & full_csrfifo) & ~flush_back;
  assign in_ready   = (~s1_valid | s1_fire_c) & ~flush_back;
  assign accept_c   = in_valid & in_ready;

  assign csr_rd_addr = s1_valid ? s1_q.addr : '0;
  assign csr_wr_en   = needs_wr_c & s1_fire_c;
  assign csr_wr_addr = s1_q.addr;
  assign csr_wr_data = new_val_c;

  // S1: issue capture with exception check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_pdst  <= '0;
      s1_rob   <= '0;
    end else if (flush_back) begin
      s1_valid <= 1'b0;
    end else if (accept_c) begin
      s1_valid   <= 1'b1;
      s1_q.op    <= csr_op_e'(in_op);
      s1_q.addr  <= in_csr_addr;
      s1_q.wdata <= in_wdata;
      s1_q.mask  <= in_mask;
      s1_q.excp  <= excp_in_c[ECODE_W];
      s1_q.ecode <= excp_in_c[ECODE_W-1:0];
      s1_pdst    <= in_pdst;
      s1_rob     <= in_rob_idx;
    end else if (s1_fire_c) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: writeback hold, stable while stalled by wb_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
      s2_pdst  <= '0;
      s2_rob   <= '0;
    end else if (flush_back) begin
      s2_valid <= 1'b0;
    end else if (s1_fire_c) begin
      s2_valid       <= 1'b1;
      s2_q.data      <= s1_q.excp ? '0 : csr_rd_data;
      s2_q.csr_write <= needs_wr_c;
      s2_q.excp      <= s1_q.excp;
      s2_q.ecode     <= s1_q.ecode;
      s2_pdst        <= s1_pdst;
      s2_rob         <= s1_rob;
    end else if (wb_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign wb_valid     = s2_valid;
  assign wb_data      = s2_q.data;
  assign wb_pdst      = s2_pdst;
  assign wb_rob_idx   = s2_rob;
  assign wb_csr_write = s2_q.csr_write;
  assign wb_excp      = s2_q.excp;
  assign wb_excp_code = s2_q.ecode;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: models the wrapper's bypassed CSR array and
// scoreboards FIFO pushes and writeback records in issue order.
module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_back;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [13:0] in_csr_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_mask;
  logic [5:0]  in_pdst;
  logic [4:0]  in_rob_idx;
  logic [1:0]  plv;
  logic [13:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_wr_en;
  logic [13:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        full_csrfifo;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [5:0]  wb_pdst;
  logic [4:0]  wb_rob_idx;
  logic        wb_csr_write;
  logic        wb_excp;
  logic [4:0]  wb_excp_code;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } push_t;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  pdst;
    logic [4:0]  rob;
    logic        csr_write;
    logic        excp;
    logic [4:0]  code;
  } wb_t;

  push_t       push_q[$];
  wb_t         wb_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] shadow [0:63];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          push_cnt = 0;
  logic        smp_acc;

  always #5 clk = ~clk;

  assign csr_rd_data = mem[csr_rd_addr[5:0]];

  csr_exec_unit #(.PDST_W(6), .ROB_W(5)) dut (
    .clk(clk), .rst(rst), .flush_back(flush_back),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_csr_addr(in_csr_addr), .in_wdata(in_wdata), .in_mask(in_mask),
    .in_pdst(in_pdst), .in_rob_idx(in_rob_idx), .plv(plv),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .full_csrfifo(full_csrfifo),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_pdst(wb_pdst), .wb_rob_idx(wb_rob_idx), .wb_csr_write(wb_csr_write),
    .wb_excp(wb_excp), .wb_excp_code(wb_excp_code)
  );

  // One cycle: sample at negedge, score pushes/writebacks, commit pushes into the CSR model.
  task automatic tick();
    logic        do_wr;
    logic [13:0] wa;
    logic [31:0] wd;
    push_t       ep;
    wb_t         ew;
    @(negedge clk);
    smp_acc = in_valid & in_ready;
    do_wr   = csr_wr_en;
    wa      = csr_wr_addr;
    wd      = csr_wr_data;
    if (do_wr) begin
      push_cnt++;
      n_tests++;
      if (push_q.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: got addr=%h data=%h, expected no push", wa, wd);
      end else begin
        ep = push_q.pop_front();
        if ({wa, wd} !== {ep.addr, ep.data}) begin
          n_fail++;
          $display("FAIL push_value: got addr=%h data=%h, expected addr=%h data=%h",
                   wa, wd, ep.addr, ep.data);
        end
      end
    end
    if (wb_valid && wb_ready) begin
      n_tests++;
      if (wb_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got data=%h pdst=%h, expected no writeback", wb_data, wb_pdst);
      end else begin
        ew = wb_q.pop_front();
        if ({wb_data, wb_pdst, wb_rob_idx, wb_csr_write, wb_excp, wb_excp_code} !==
            {ew.data, ew.pdst, ew.rob, ew.csr_write, ew.excp, ew.code}) begin
          n_fail++;
          $display("FAIL wb_value: got data=%h pdst=%h rob=%h wr=%b excp=%b code=%h, expected data=%h pdst=%h rob=%h wr=%b excp=%b code=%h",
                   wb_data, wb_pdst, wb_rob_idx, wb_csr_write, wb_excp, wb_excp_code,
                   ew.data, ew.pdst, ew.rob, ew.csr_write, ew.excp, ew.code);
        end
      end
    end
    @(posedge clk);
    if (do_wr) mem[wa[5:0]] <= wd;
    #1;
  endtask

  task automatic exp_push(input logic [13:0] a, input logic [31:0] d);
    push_t p;
    p.addr = a;
    p.data = d;
    push_q.push_back(p);
  endtask

  task automatic exp_wb(input logic [31:0] d, input logic [5:0] pd, input logic [4:0] rb,
                        input logic wr, input logic ex, input logic [4:0] code);
    wb_t w;
    w.data = d; w.pdst = pd; w.rob = rb; w.csr_write = wr; w.excp = ex; w.code = code;
    wb_q.push_back(w);
  endtask

  // Present an op and hold it until accepted; leaves in_valid low on return.
  task automatic issue(input logic [1:0] op, input logic [13:0] a, input logic [31:0] wd,
                       input logic [31:0] mk, input logic [5:0] pd, input logic [4:0] rb);
    int guard;
    guard       = 0;
    in_valid    = 1'b1;
    in_op       = op;
    in_csr_addr = a;
    in_wdata    = wd;
    in_mask     = mk;
    in_pdst     = pd;
    in_rob_idx  = rb;
    do begin
      tick();
      guard++;
    end while (!smp_acc && guard < 20);
    in_valid = 1'b0;
    if (!smp_acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got no accept in %0d cycles, expected accept", guard);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    n_tests++;
    if (push_q.size() != 0 || wb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pushes and %0d writebacks outstanding, expected 0 and 0",
               push_q.size(), wb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_back = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_csr_addr = '0;
    in_wdata = '0; in_mask = '0; in_pdst = '0; in_rob_idx = '0; plv = 2'd0;
    full_csrfifo = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] <= '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({wb_valid, csr_wr_en, csr_rd_addr, csr_wr_addr, csr_wr_data, wb_data, wb_pdst,
         wb_rob_idx, wb_csr_write, wb_excp, wb_excp_code} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wb_valid=%b wr_en=%b rd_addr=%h wb_data=%h excp=%b, expected all 0",
               wb_valid, csr_wr_en, csr_rd_addr, wb_data, wb_excp);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_csrwr();
    mem[6] <= 32'h0;
    exp_push(14'h6, 32'h1C000100);
    exp_wb(32'h0, 6'd1, 5'd1, 1'b1, 1'b0, 5'h0);
    issue(2'b01, 14'h6, 32'h1C000100, 32'h0, 6'd1, 5'd1);
    n_tests++;
    if ({csr_wr_en, wb_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL csrwr_n1: got wr_en=%b wb_valid=%b, expected wr_en=1 wb_valid=0", csr_wr_en, wb_valid);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL csrwr_n2: got wb_valid=%b, expected 1", wb_valid);
    end
    drain(3);
  endtask

  task automatic test_xchg();
    mem[1] <= 32'hFFFF0000;
    exp_push(14'h1, 32'hFF340078);
    exp_wb(32'hFFFF0000, 6'd2, 5'd2, 1'b1, 1'b0, 5'h0);
    issue(2'b10, 14'h1, 32'h12345678, 32'h00FF00FF, 6'd2, 5'd2);
    drain(4);
  endtask

  task automatic test_back_to_back();
    mem[12] <= 32'h0;
    exp_push(14'hC, 32'hAAAA0000);
    exp_wb(32'h0, 6'd3, 5'd3, 1'b1, 1'b0, 5'h0);
    exp_wb(32'hAAAA0000, 6'd4, 5'd4, 1'b0, 1'b0, 5'h0);
    issue(2'b01, 14'hC, 32'hAAAA0000, 32'h0, 6'd3, 5'd3);
    issue(2'b00, 14'hC, 32'h0, 32'h0, 6'd4, 5'd4);
    drain(4);
  endtask

  task automatic test_fifo_full();
    int pc0;
    mem[2] <= 32'h0;
    full_csrfifo = 1'b1;
    exp_push(14'h2, 32'h11112222);
    exp_wb(32'h0, 6'd5, 5'd5, 1'b1, 1'b0, 5'h0);
    issue(2'b01, 14'h2, 32'h11112222, 32'h0, 6'd5, 5'd5);
    pc0 = push_cnt;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({csr_wr_en, in_ready, wb_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL full_stall%0d: got wr_en=%b in_ready=%b wb_valid=%b, expected 0 0 0",
                 i, csr_wr_en, in_ready, wb_valid);
      end
      tick();
    end
    full_csrfifo = 1'b0;
    drain(4);
    n_tests++;
    if (push_cnt - pc0 != 1) begin
      n_fail++;
      $display("FAIL full_push_count: got %0d pushes, expected 1", push_cnt - pc0);
    end
    full_csrfifo = 1'b1;
    exp_wb(32'h11112222, 6'd6, 5'd6, 1'b0, 1'b0, 5'h0);
    issue(2'b00, 14'h2, 32'h0, 32'h0, 6'd6, 5'd6);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rd_ready: got in_ready=%b, expected 1", in_ready);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rd_wb: got wb_valid=%b, expected 1", wb_valid);
    end
    full_csrfifo = 1'b0;
    drain(3);
  endtask

  task automatic test_excp();
    plv = 2'd3;
    exp_wb(32'h0, 6'd7, 5'd7, 1'b0, 1'b1, 5'h1C);
    issue(2'b01, 14'h3, 32'h5, 32'h0, 6'd7, 5'd7);
    exp_wb(32'h0, 6'd8, 5'd8, 1'b0, 1'b1, 5'h1C);
    issue(2'b11, 14'h3, 32'h5, 32'h0, 6'd8, 5'd8);
    plv = 2'd0;
    exp_wb(32'h0, 6'd9, 5'd9, 1'b0, 1'b1, 5'h1A);
    issue(2'b11, 14'h3, 32'h5, 32'h0, 6'd9, 5'd9);
    drain(4);
  endtask

  task automatic test_flush_backpressure();
    int pc0;
    mem[5] <= 32'h00005555;
    mem[4] <= 32'h0;
    wb_ready = 1'b0;
    issue(2'b00, 14'h5, 32'h0, 32'h0, 6'd10, 5'd10);
    issue(2'b01, 14'h4, 32'h9, 32'h0, 6'd11, 5'd11);
    pc0 = push_cnt;
    n_tests++;
    if ({wb_valid, in_ready, csr_wr_en} !== 3'b100 || wb_data !== 32'h00005555) begin
      n_fail++;
      $display("FAIL bp_hold: got wb_valid=%b in_ready=%b wr_en=%b data=%h, expected 1 0 0 00005555",
               wb_valid, in_ready, csr_wr_en, wb_data);
    end
    tick();
    n_tests++;
    if ({wb_valid, wb_pdst, wb_data} !== {1'b1, 6'd10, 32'h00005555}) begin
      n_fail++;
      $display("FAIL bp_stable: got valid=%b pdst=%h data=%h, expected 1 0a 00005555",
               wb_valid, wb_pdst, wb_data);
    end
    flush_back  = 1'b1;
    in_valid    = 1'b1;
    in_op       = 2'b01;
    in_csr_addr = 14'h7;
    in_wdata    = 32'hDEAD;
    n_tests++;
    if ({in_ready, csr_wr_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_cycle: got in_ready=%b wr_en=%b, expected 0 0", in_ready, csr_wr_en);
    end
    tick();
    flush_back = 1'b0;
    in_valid   = 1'b0;
    n_tests++;
    if ({wb_valid, csr_wr_en, csr_rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL flush_after: got wb_valid=%b wr_en=%b rd_addr=%h, expected 0 0 0",
               wb_valid, csr_wr_en, csr_rd_addr);
    end
    tick();
    n_tests++;
    if ({in_ready, wb_valid} !== 2'b10 || push_cnt != pc0) begin
      n_fail++;
      $display("FAIL flush_recover: got in_ready=%b wb_valid=%b pushes=%0d, expected 1 0 0",
               in_ready, wb_valid, push_cnt - pc0);
    end
    wb_ready = 1'b1;
    drain(3);
  endtask

  // In-order stream against a shadow CSR model; each op sees all earlier pushes.
  task automatic test_stream();
    logic [1:0]  op;
    logic [5:0]  a;
    logic [31:0] wd, mk, old, nv;
    for (int i = 8; i < 12; i++) begin
      mem[i]    <= 32'h1000_0000 * i;
      shadow[i]  = 32'h1000_0000 * i;
    end
    for (int k = 0; k < 16; k++) begin
      op  = 2'($urandom_range(0, 2));
      a   = 6'($urandom_range(8, 11));
      wd  = $urandom;
      mk  = $urandom;
      old = shadow[a];
      nv  = (op == 2'b10) ? ((old & ~mk) | (wd & mk)) : wd;
      if (op != 2'b00) begin
        shadow[a] = nv;
        exp_push(14'(a), nv);
      end
      exp_wb(old, 6'(k + 16), 5'(k), op != 2'b00, 1'b0, 5'h0);
      issue(op, 14'(a), wd, mk, 6'(k + 16), 5'(k));
    end
    drain(5);
  endtask

  initial begin
    test_reset();
    test_csrwr();
    test_xchg();
    test_back_to_back();
    test_fifo_full();
    test_excp();
    test_flush_backpressure();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Execute unit for CSR instructions (`csrrd`, `csrwr`, `csrxchg`), placed directly upstream of `csr_wrapper`. It takes issued CSR micro-ops and reads the current CSR value through the wrapper's bypassed read port. It computes the merged write value and pushes it into the wrapper's speculative CSR FIFO. It then returns the old CSR value, tag and exception status to writeback/ROB. Two-stage pipeline: S1 is read/compute/push, S2 is writeback hold. Throughput is one op per cycle.

## Interface
Parameters:
- `PDST_W`, default 6: physical destination tag width.
- `ROB_W`, default 5: ROB index width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `flush_back`  in  1  pipeline flush; kills all in-flight ops
- `in_valid` / `in_ready`  in / out  1 / 1  issue handshake
- `in_op`  in  2  00 CSRRD, 01 CSRWR, 10 CSRXCHG, 11 illegal
- `in_csr_addr`  in  14  CSR number
- `in_wdata`  in  32  rd source value (write value)
- `in_mask`  in  32  rj source value (xchg mask)
- `in_pdst`  in  PDST_W  destination tag
- `in_rob_idx`  in  ROB_W  ROB index
- `plv`  in  2  current privilege level, from wrapper `plv_out`
- `csr_rd_addr`  out  14  to wrapper `rd_addr`
- `csr_rd_data`  in  32  from wrapper `rd_data`, combinational, FIFO-bypassed
- `csr_wr_en`, `csr_wr_addr`, `csr_wr_data`  out  1/14/32  push into wrapper FIFO
- `full_csrfifo`  in  1  wrapper FIFO full
- `wb_valid` / `wb_ready`  out / in  1 / 1  writeback handshake
- `wb_data`  out  32  old CSR value
- `wb_pdst`, `wb_rob_idx`  out  tag and ROB index
- `wb_csr_write`  out  1  op pushed a FIFO entry; ROB asserts `csrWr_rob` at commit
- `wb_excp`, `wb_excp_code`  out  1/5  exception flag and code, format {ecode[3:0], esubcode[0]}

## Operation
- **S1 capture:** S1 loads on `in_valid & in_ready`. The op is checked for exceptions when it is registered:
  - `plv != 0` gives IPE, code 5'h1C.
  - op 11 gives INE, code 5'h1A.
  - IPE has priority over INE.
- **S1 read:** `csr_rd_addr = s1_addr` whenever S1 is valid. Otherwise it is 0.
- **Write value:**
  - CSRWR: `new = wdata`.
  - CSRXCHG: `new = (old & ~mask) | (wdata & mask)`, where `old = csr_rd_data`.
  - CSRRD: no write.
- **needs_wr:** `s1_valid & (op==CSRWR | op==CSRXCHG) & ~s1_excp`.
- **s2_free:** `~s2_valid | wb_ready`.
- **s1_fire:** `s1_valid & s2_free & ~(needs_wr & full_csrfifo) & ~flush_back`.
- **FIFO push:** `csr_wr_en = needs_wr & s1_fire`, with `csr_wr_addr = s1_addr` and `csr_wr_data = new`. Push occurs only on `s1_fire`, so each op pushes exactly once.
- **in_ready:** `(~s1_valid | s1_fire) & ~flush_back`.
- **S2 load:** on `s1_fire`, S2 captures `old`, pdst, rob_idx, `wb_csr_write = needs_wr`, and the exception fields. An excepting op returns `wb_data = 0` and never pushes.
- **Back-to-back ops to the same CSR:** the first op's push is visible through the wrapper bypass in the next cycle, when the second op sits in S1. No internal hazard logic is required.
- **Flush:** `flush_back` clears `s1_valid` and `s2_valid` on the next edge. In the flush cycle the block forces `csr_wr_en = 0` and `in_ready = 0`. The wrapper clears its FIFO on the same flush.

## Timing
- **Reset:** all valids are 0, and every output is 0 except `in_ready`. `in_ready` is 1 after reset release.
- **Latency:**
  - Issue accepted at edge N.
  - The CSR read and FIFO push happen in cycle N+1.
  - `wb_valid` is high from N+2.
- **Stalls:**
  - `full_csrfifo` holds a write op in S1. The op is not pushed, and `in_ready` drops.
  - A read-only op proceeds regardless of `full_csrfifo`.
  - `wb_ready = 0` holds S2 stable, and S1 stalls behind it.
- **S2 handshake:** S2 outputs must remain stable while `wb_valid & ~wb_ready`.
- **Flush vs accept:** flush in the same cycle as `in_valid` means the op is not accepted.
- **Reset mid-operation:** everything is dropped asynchronously.

## Structure
- **Package `csr_exec_pkg`:**
  - `csr_op_e` enum.
  - Ecode constants IPE and INE.
  - The S1/S2 stage structs.
- **Sub-module `csr_merge`:** combinational op decode plus mask merge, instantiated in S1.
- **Top:** handshake, stall, flush and both pipeline registers.

## Test plan
1. **CSRWR:** reset, `plv=0`. Issue CSRWR to 14'h6 with wdata 32'h1C000100 while the CSR holds 32'h0.
   - Expect `csr_wr_en` one cycle later with addr 14'h6 and data 32'h1C000100.
   - Expect `wb_valid` at N+2 with `wb_data = 0` and `wb_csr_write = 1`.
2. **CSRXCHG merge:** the CSR holds 32'hFFFF0000. Issue CSRXCHG with mask 32'h00FF00FF and wdata 32'h12345678.
   - Expect push data 32'hFF340078.
   - Expect `wb_data = 32'hFFFF0000`.
3. **Back-to-back:** CSRWR to 14'hC with 32'hAAAA0000, then CSRRD of 14'hC on the next cycle.
   - Expect the CSRRD to return 32'hAAAA0000 through the bypass.
   - Expect `wb_csr_write = 0` for the CSRRD.
4. **FIFO full:** hold `full_csrfifo = 1` for 3 cycles with a CSRWR in S1.
   - Expect `csr_wr_en = 0` and `in_ready = 0` during the stall.
   - Expect exactly one push after release.
   - A CSRRD under a full FIFO proceeds without stalling.
5. **Exceptions:**
   - With `plv = 3`, CSRWR gives `wb_excp = 1`, code 5'h1C, and no push.
   - With `plv = 0`, op 11 gives code 5'h1A.
6. **Flush and backpressure:** `wb_ready = 0` with S1 and S2 full, then pulse `flush_back`.
   - No push occurs and both valids are 0 on the next cycle.
   - `in_ready` returns to 1 one cycle later.
